// File: rtl/uart_rx.sv
// 8N1 UART receiver with a double-flop input synchronizer, mid-bit sampling and
// sticky frame-error / overrun status. Reception runs only while rx_en is high.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_en,
  input  logic       clear_flag,
  output logic [7:0] rx_data,
  output logic       receive_flag,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] baud_cnt, cnt_next;
  logic [2:0]    bit_cnt, bit_next;
  logic [7:0]    shift, shift_next;
  logic          rx_meta, rx_sync, rx_prev;
  logic [1:0]    sync_ok;
  logic          armed;
  logic          accept, lose, ferr;

  // sync_ok marks when rx_sync holds a real line value rather than its reset
  // value, so a line held low across reset release is never taken as a start.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      sync_ok <= 2'b00;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      sync_ok <= {sync_ok[0], 1'b1};
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      armed    <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= cnt_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      if (ferr)
        armed <= 1'b0;
      else if (state == IDLE && sync_ok[1] && rx_sync)
        armed <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = baud_cnt + 1'b1;
    bit_next   = bit_cnt;
    shift_next = shift;
    accept     = 1'b0;
    lose       = 1'b0;
    ferr       = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (rx_en && armed && rx_prev && !rx_sync) begin
          state_next = START;
          bit_next   = '0;
        end
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_sync, shift[7:1]};
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_next = STOP;
        end
      end
      STOP: begin
        if (baud_cnt == BIT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (!rx_sync)
            ferr = 1'b1;
          else if (!receive_flag || clear_flag)
            accept = 1'b1;
          else
            lose = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // Dropping rx_en abandons the frame without touching data or status.
    if (state != IDLE && !rx_en) begin
      state_next = IDLE;
      cnt_next   = '0;
      accept     = 1'b0;
      lose       = 1'b0;
      ferr       = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= 8'h00;
      receive_flag <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (accept)
        rx_data <= shift;
      if (accept)
        receive_flag <= 1'b1;
      else if (clear_flag)
        receive_flag <= 1'b0;
      if (ferr)
        frame_err <= 1'b1;
      else if (clear_flag)
        frame_err <= 1'b0;
      if (lose)
        overrun <= 1'b1;
      else if (clear_flag)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit: a vector table of frames
// followed by hand-written sequences for timing, glitch, abort and reset cases.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx_en;
  logic       clear_flag;
  logic [7:0] rx_data;
  logic       receive_flag;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int passed = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .rx           (rx),
    .rx_en        (rx_en),
    .clear_flag   (clear_flag),
    .rx_data      (rx_data),
    .receive_flag (receive_flag),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       do_clear;
    logic [7:0] exp_data;
    logic       exp_flag;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[6];

  task automatic check_byte(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    else
      passed++;
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    else
      passed++;
  endtask

  task automatic check_output(input string tag, input logic [7:0] e_data, input logic e_flag,
                              input logic e_fe, input logic e_ov);
    @(negedge clock);
    check_byte({tag, ".rx_data"}, rx_data, e_data);
    check_bit({tag, ".receive_flag"}, receive_flag, e_flag);
    check_bit({tag, ".frame_err"}, frame_err, e_fe);
    check_bit({tag, ".overrun"}, overrun, e_ov);
  endtask

  // Start bit is driven just after the first posedge seen here; that edge is
  // the reference "edge k" for any timing watcher forked alongside.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop);
    @(posedge clock);
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      #1 rx = data[i];
      repeat (CPB) @(posedge clock);
    end
    #1 rx = stop;
    repeat (CPB) @(posedge clock);
    #1 rx = 1'b1;
  endtask

  task automatic pulse_clear();
    @(posedge clock);
    #1 clear_flag = 1'b1;
    @(posedge clock);
    #1 clear_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hC3, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    rst_n      = 1'b0;
    rx         = 1'b1;
    rx_en      = 1'b1;
    clear_flag = 1'b0;
    idle(3);
    check_output("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1 rst_n = 1'b1;
    idle(10);

    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].data, vecs[v].stop);
      idle(4);
      check_output($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_flag,
                   vecs[v].exp_fe, vecs[v].exp_ov);
      if (vecs[v].do_clear) begin
        pulse_clear();
        check_output($sformatf("vec%0d_clr", v), vecs[v].exp_data, 1'b0, 1'b0, 1'b0);
      end
      idle(4);
    end

    // receive_flag must rise exactly one cycle after the stop sample.
    fork
      apply_stimulus(8'h96, 1'b1);
      begin
        @(posedge clock);
        repeat (154) @(posedge clock);
        @(negedge clock);
        check_bit("latency_before", receive_flag, 1'b0);
        @(negedge clock);
        check_bit("latency_after", receive_flag, 1'b1);
      end
    join
    idle(4);
    check_output("lat_byte", 8'h96, 1'b1, 1'b0, 1'b0);
    pulse_clear();
    idle(4);

    // Short low pulse must be rejected at the start-bit midpoint.
    @(posedge clock);
    #1 rx = 1'b0;
    repeat (5) @(posedge clock);
    #1 rx = 1'b1;
    idle(30);
    check_output("glitch", 8'h96, 1'b0, 1'b0, 1'b0);
    apply_stimulus(8'h01, 1'b1);
    idle(4);
    check_output("after_glitch", 8'h01, 1'b1, 1'b0, 1'b0);

    // clear_flag coincides with the stop sample while a byte is still held.
    fork
      apply_stimulus(8'h7E, 1'b1);
      begin
        @(posedge clock);
        repeat (154) @(posedge clock);
        #1 clear_flag = 1'b1;
        @(posedge clock);
        #1 clear_flag = 1'b0;
      end
    join
    idle(4);
    check_output("clear_same_cycle", 8'h7E, 1'b1, 1'b0, 1'b0);
    pulse_clear();
    idle(4);

    // Disabling mid-frame abandons the byte.
    fork
      apply_stimulus(8'h5A, 1'b1);
      begin
        repeat (60) @(posedge clock);
        #1 rx_en = 1'b0;
      end
    join
    idle(10);
    check_output("abort", 8'h7E, 1'b0, 1'b0, 1'b0);
    #1 rx_en = 1'b1;
    idle(10);
    apply_stimulus(8'h5A, 1'b1);
    idle(4);
    check_output("after_abort", 8'h5A, 1'b1, 1'b0, 1'b0);
    #1 rx_en = 1'b0;
    idle(3);
    check_bit("flag_while_disabled", receive_flag, 1'b1);
    #1 rx_en = 1'b1;
    idle(4);

    // Reset during the data bits of 0xFF, then a clean 0x81.
    fork
      apply_stimulus(8'hFF, 1'b1);
      begin
        repeat (50) @(posedge clock);
        #1 rst_n = 1'b0;
        check_output("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
      end
    join
    idle(20);
    check_output("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    apply_stimulus(8'h81, 1'b1);
    idle(4);
    check_output("after_reset", 8'h81, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
